// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Included by the arbiter top and its access-legality checker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_align_check.sv
// Combinational legality check for one RV32 load/store: flags misaligned
// addresses and funct3 codes that are not valid for the access direction.
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] funct3,
  input  logic       we,
  output logic       err
);

  // Unsigned sub-word codes exist only for loads; anything unlisted is illegal.
  always_comb begin
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_BU:   err = we;
      F3_H:    err = addr_lo[0];
      F3_HU:   err = we | addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between fetch (I) and LSU (D),
// sequencing each access as accept / command / capture / response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  output logic              i_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic              d_req_we,
  input  logic [2:0]        d_req_funct3,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  output logic [2:0]        m_funct3,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int CNT_W = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [2:0]        m_funct3_q, m_funct3_d;
  logic              i_rsp_valid_q, i_rsp_valid_d;
  logic [DATA_W-1:0] i_rsp_data_q, i_rsp_data_d;
  logic              i_rsp_err_q, i_rsp_err_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_W-1:0] d_rsp_data_q, d_rsp_data_d;
  logic              d_rsp_err_q, d_rsp_err_d;
  logic              busy_q, busy_d;

  logic              idle_s;
  logic              grant_d_s;
  logic              grant_i_s;
  logic              accept_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic              acc_we_s;
  logic [2:0]        acc_f3_s;
  logic              acc_err_s;

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    idle_s    = (state_q == IDLE) & rst_n;
    grant_d_s = d_req_valid & ~(i_req_valid & (starve_q == LIM));
    grant_i_s = i_req_valid & ~grant_d_s;
    accept_s  = idle_s & (grant_d_s | grant_i_s);
    if (grant_d_s) begin
      acc_addr_s = d_req_addr;
      acc_we_s   = d_req_we;
      acc_f3_s   = d_req_funct3;
    end else begin
      acc_addr_s = i_req_addr;
      acc_we_s   = 1'b0;
      acc_f3_s   = F3_W;
    end
  end

  assign d_req_ready = idle_s & grant_d_s;
  assign i_req_ready = idle_s & grant_i_s;

  mem_align_check u_align (
    .addr_lo (acc_addr_s[1:0]),
    .funct3  (acc_f3_s),
    .we      (acc_we_s),
    .err     (acc_err_s)
  );

  // Next-state, strobe and response computation for the access sequencer.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    starve_d      = starve_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    m_read_d      = 1'b0;
    m_write_d     = 1'b0;
    m_funct3_d    = 3'b000;
    i_rsp_valid_d = 1'b0;
    i_rsp_data_d  = i_rsp_data_q;
    i_rsp_err_d   = i_rsp_err_q;
    d_rsp_valid_d = 1'b0;
    d_rsp_data_d  = d_rsp_data_q;
    d_rsp_err_d   = d_rsp_err_q;

    // Starvation bookkeeping applies to error grants as well as legal ones.
    if (d_req_ready && i_req_valid) begin
      if (starve_q != LIM) begin
        starve_d = starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        starve_d = starve_q;
      end
    end else if (i_req_ready) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          owner_d = grant_d_s ? OWN_D : OWN_I;
          we_d    = acc_we_s;
          if (acc_err_s) begin
            state_d = RESP;
            if (grant_d_s) begin
              d_rsp_valid_d = 1'b1;
              d_rsp_data_d  = '0;
              d_rsp_err_d   = 1'b1;
            end else begin
              i_rsp_valid_d = 1'b1;
              i_rsp_data_d  = '0;
              i_rsp_err_d   = 1'b1;
            end
          end else begin
            state_d    = ISSUE;
            m_addr_d   = acc_addr_s;
            m_wdata_d  = grant_d_s ? d_req_wdata : '0;
            m_read_d   = ~acc_we_s;
            m_write_d  = acc_we_s;
            m_funct3_d = acc_f3_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        state_d = RESP;
        if (owner_q == OWN_D) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_data_d  = we_q ? '0 : m_rdata;
          d_rsp_err_d   = 1'b0;
        end else begin
          i_rsp_valid_d = 1'b1;
          i_rsp_data_d  = m_rdata;
          i_rsp_err_d   = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_I;
      we_q          <= 1'b0;
      starve_q      <= '0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_funct3_q    <= 3'b000;
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      i_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= '0;
      d_rsp_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      starve_q      <= starve_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_funct3_q    <= m_funct3_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_data_q  <= i_rsp_data_d;
      i_rsp_err_q   <= i_rsp_err_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_data_q  <= d_rsp_data_d;
      d_rsp_err_q   <= d_rsp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_funct3    = m_funct3_q;
  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_data  = i_rsp_data_q;
  assign i_rsp_err   = i_rsp_err_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign busy        = busy_q;

endmodule
